mux_sel_scanner: RTL and testbench

- Upstream select sequencer for the parameterised WIDTH:1 data-flow mux.
- Accepts a WIDTH-bit word through a valid/ready handshake and holds it on the mux data bus.
- Steps the mux select through every index, one per un-held clock, so the mux output becomes a serial bit stream.
- Flags each valid select beat, marks the final beat, and pulses done when the word is finished.

---
 rtl/mux_sel_scanner.sv | 141 ++++++++++++++
 tb/tb_mux_sel_scanner.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : mux_sel_scanner
//  Brief    : Select sequencer for a WIDTH:1 mux. Latches a word through a
//             valid/ready handshake, then walks the mux select across every
//             index (one index per un-held clock) so the mux output becomes
//             a serial bit stream. Flags live beats and the final beat, and
//             pulses done once the word has been fully consumed.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_sel_scanner #(
  // Word width and number of mux inputs; must be 2 or more.
  parameter int WIDTH     = 4,
  // Scan order: 0 walks index 0 up to WIDTH-1, 1 walks WIDTH-1 down to 0.
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     hold,
  output logic [WIDTH-1:0]         mux_i,
  output logic [$clog2(WIDTH)-1:0] mux_s,
  output logic                     sel_valid,
  output logic                     last,
  output logic                     done
);

  localparam int c_sel_w = $clog2(WIDTH);

  // First and final select index of a word, set by the scan order. The
  // index is always reloaded with c_start rather than allowed to overflow,
  // which keeps it inside 0..WIDTH-1 for non-power-of-two widths.
  localparam logic [c_sel_w-1:0] c_start = MSB_FIRST ? c_sel_w'(WIDTH - 1) : '0;
  localparam logic [c_sel_w-1:0] c_end   = MSB_FIRST ? '0 : c_sel_w'(WIDTH - 1);
  localparam logic [c_sel_w-1:0] c_one   = c_sel_w'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_mux_i;
  logic [WIDTH-1:0]     w_mux_i_next;
  logic [c_sel_w-1:0]   r_mux_s;
  logic [c_sel_w-1:0]   w_mux_s_next;
  logic [c_sel_w-1:0]   w_step_s;
  logic                 r_sel_valid;
  logic                 w_sel_valid_next;
  logic                 r_done;
  logic                 w_done_next;
  logic                 w_last;
  logic                 w_in_ready;

  // Select index one step closer to c_end, direction fixed by scan order.
  generate
    if (MSB_FIRST) begin : g_scan_down
      assign w_step_s = r_mux_s - c_one;
    end else begin : g_scan_up
      assign w_step_s = r_mux_s + c_one;
    end
  endgenerate

  // The final beat is the live beat sitting on the end index.
  assign w_last = r_sel_valid && (r_mux_s == c_end);

  // A new word may enter while idle, or on the very cycle the final beat of
  // the current word is consumed, which gives gap-free back-to-back words.
  assign w_in_ready = (r_state == S_IDLE) ||
                      ((r_state == S_SCAN) && w_last && !hold);

  // Next-state and next-register values; everything holds unless told otherwise.
  always_comb begin
    w_state_next     = r_state;
    w_mux_i_next     = r_mux_i;
    w_mux_s_next     = r_mux_s;
    w_sel_valid_next = r_sel_valid;
    w_done_next      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sel_valid_next = 1'b0;
        if (in_valid) begin
          w_mux_i_next     = in_data;
          w_mux_s_next     = c_start;
          w_sel_valid_next = 1'b1;
          w_state_next     = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!hold) begin
          if (w_last) begin
            w_done_next = 1'b1;
            if (in_valid) begin
              w_mux_i_next     = in_data;
              w_mux_s_next     = c_start;
              w_sel_valid_next = 1'b1;
            end else begin
              w_sel_valid_next = 1'b0;
              w_state_next     = S_IDLE;
            end
          end else begin
            w_mux_s_next = w_step_s;
          end
        end
      end
      default: begin
        w_state_next     = S_IDLE;
        w_sel_valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mux_i     <= '0;
      r_mux_s     <= '0;
      r_sel_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mux_i     <= w_mux_i_next;
      r_mux_s     <= w_mux_s_next;
      r_sel_valid <= w_sel_valid_next;
      r_done      <= w_done_next;
    end
  end

  assign in_ready  = w_in_ready;
  assign mux_i     = r_mux_i;
  assign mux_s     = r_mux_s;
  assign sel_valid = r_sel_valid;
  assign last      = w_last;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_sel_scanner
//  Brief    : Scoreboard bench for mux_sel_scanner. Three instances cover
//             WIDTH=4 LSB-first (id 0), WIDTH=4 MSB-first (id 1) and
//             WIDTH=8 LSB-first (id 2). Expected beats are queued as words
//             are issued; a monitor per instance pops them on consumed beats.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sel_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: WIDTH=4, LSB first
  logic       a_vld = 1'b0, a_hld = 1'b0;
  logic [3:0] a_dat = '0;
  logic       a_rdy, a_sv, a_last, a_done;
  logic [3:0] a_mi;
  logic [1:0] a_ms;
  // instance 1: WIDTH=4, MSB first
  logic       b_vld = 1'b0, b_hld = 1'b0;
  logic [3:0] b_dat = '0;
  logic       b_rdy, b_sv, b_last, b_done;
  logic [3:0] b_mi;
  logic [1:0] b_ms;
  // instance 2: WIDTH=8, LSB first
  logic       c_vld = 1'b0, c_hld = 1'b0;
  logic [7:0] c_dat = '0;
  logic       c_rdy, c_sv, c_last, c_done;
  logic [7:0] c_mi;
  logic [2:0] c_ms;

  mux_sel_scanner #(.WIDTH(4), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_vld), .in_data(a_dat), .in_ready(a_rdy),
    .hold(a_hld), .mux_i(a_mi), .mux_s(a_ms), .sel_valid(a_sv), .last(a_last), .done(a_done));
  mux_sel_scanner #(.WIDTH(4), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_vld), .in_data(b_dat), .in_ready(b_rdy),
    .hold(b_hld), .mux_i(b_mi), .mux_s(b_ms), .sel_valid(b_sv), .last(b_last), .done(b_done));
  mux_sel_scanner #(.WIDTH(8), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_vld), .in_data(c_dat), .in_ready(c_rdy),
    .hold(c_hld), .mux_i(c_mi), .mux_s(c_ms), .sel_valid(c_sv), .last(c_last), .done(c_done));

  typedef struct {
    int s;
    bit y;
    bit l;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t q2[$];
  bit    pend[3];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Queue one hand-computed expected beat: select index, mux output bit, last flag.
  task automatic exp_beat(input int id, input int s, input bit y, input bit l);
    beat_t b;
    b.s = s; b.y = y; b.l = l;
    case (id)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  function automatic int qsize(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic beat_t qpop(input int id);
    case (id)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic rdy_of(input int id);
    case (id)
      0: return a_rdy;
      1: return b_rdy;
      default: return c_rdy;
    endcase
  endfunction

  // One monitor step at a negative edge: check done against the pending
  // expectation, then pop and compare if a beat is consumed.
  task automatic mon_step(input int id, input logic sv, input logic hd, input logic lst,
                          input logic dn, input logic [7:0] mi, input int ms);
    beat_t e;
    if (rst) begin
      pend[id] = 1'b0;
      return;
    end
    chk($sformatf("done_id%0d", id), int'(dn), int'(pend[id]));
    pend[id] = 1'b0;
    if (sv && !hd) begin
      if (qsize(id) == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected_id%0d actual=beat_at_s%0d required=no_beat", id, ms);
      end else begin
        e = qpop(id);
        chk($sformatf("sel_id%0d", id), ms, e.s);
        chk($sformatf("y_id%0d_s%0d", id, e.s), int'(mi[ms]), int'(e.y));
        chk($sformatf("last_id%0d_s%0d", id, e.s), int'(lst), int'(e.l));
        if (e.l) pend[id] = 1'b1;
      end
    end
  endtask

  initial forever begin @(negedge clk); mon_step(0, a_sv, a_hld, a_last, a_done, {4'b0, a_mi}, int'(a_ms)); end
  initial forever begin @(negedge clk); mon_step(1, b_sv, b_hld, b_last, b_done, {4'b0, b_mi}, int'(b_ms)); end
  initial forever begin @(negedge clk); mon_step(2, c_sv, c_hld, c_last, c_done, c_mi, int'(c_ms)); end

  // Present a word and wait (bounded) for it to be accepted. Returns just
  // after the accepting edge, i.e. at the start of the first beat's cycle.
  task automatic send(input int id, input logic [7:0] d, input bit keep);
    int  n;
    logic r;
    case (id)
      0: begin a_vld = 1'b1; a_dat = d[3:0]; end
      1: begin b_vld = 1'b1; b_dat = d[3:0]; end
      default: begin c_vld = 1'b1; c_dat = d; end
    endcase
    n = 0;
    do begin
      @(negedge clk);
      r = rdy_of(id);
      n++;
    end while (!r && n < 200);
    chk($sformatf("accept_id%0d", id), int'(r), 1);
    @(posedge clk); #1;
    if (!keep) begin
      case (id)
        0: a_vld = 1'b0;
        1: b_vld = 1'b0;
        default: c_vld = 1'b0;
      endcase
    end
  endtask

  // Wait n negedges after send() returns and check the block is back to idle.
  task automatic idle_chk(input int id, input int n);
    repeat (n) @(negedge clk);
    case (id)
      0: begin chk("idle_sv_id0", int'(a_sv), 0); chk("idle_rdy_id0", int'(a_rdy), 1); end
      1: begin chk("idle_sv_id1", int'(b_sv), 0); chk("idle_rdy_id1", int'(b_rdy), 1); end
      default: begin chk("idle_sv_id2", int'(c_sv), 0); chk("idle_rdy_id2", int'(c_rdy), 1); end
    endcase
    @(posedge clk); #1;
  endtask

  initial begin
    logic [6:0] hp;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mux_i", int'(a_mi), 0);
    chk("rst_mux_s", int'(a_ms), 0);
    chk("rst_sel_valid", int'(a_sv), 0);
    chk("rst_last", int'(a_last), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_in_ready", int'(a_rdy), 1);
    chk("rst_c_mux_s", int'(c_ms), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single word, LSB first: 1011 -> s 0,1,2,3 / y 1,1,0,1
    exp_beat(0, 0, 1, 0); exp_beat(0, 1, 1, 0); exp_beat(0, 2, 0, 0); exp_beat(0, 3, 1, 1);
    send(0, 8'h0B, 1'b0);
    idle_chk(0, 5);

    // Same word, MSB first: s 3,2,1,0 / y 1,0,1,1
    exp_beat(1, 3, 1, 0); exp_beat(1, 2, 0, 0); exp_beat(1, 1, 1, 0); exp_beat(1, 0, 1, 1);
    send(1, 8'h0B, 1'b0);
    idle_chk(1, 5);

    // Back-to-back 1011 then 0110 with in_valid held high
    exp_beat(0, 0, 1, 0); exp_beat(0, 1, 1, 0); exp_beat(0, 2, 0, 0); exp_beat(0, 3, 1, 1);
    exp_beat(0, 0, 0, 0); exp_beat(0, 1, 1, 0); exp_beat(0, 2, 1, 0); exp_beat(0, 3, 0, 1);
    send(0, 8'h0B, 1'b1);
    fork
      send(0, 8'h06, 1'b0);
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          chk($sformatf("b2b_sv_beat%0d", i), int'(a_sv), 1);
        end
      end
    join
    idle_chk(0, 5);

    // Hold: word 1101, hold two cycles at s=1 and one cycle at s=3
    exp_beat(0, 0, 1, 0); exp_beat(0, 1, 0, 0); exp_beat(0, 2, 1, 0); exp_beat(0, 3, 1, 1);
    send(0, 8'h0D, 1'b0);
    hp = 7'b0100110;
    for (int i = 1; i <= 7; i++) begin
      a_hld = hp[i-1];
      @(negedge clk);
      if (i >= 2 && i <= 4) chk($sformatf("hold_s1_cyc%0d", i), int'(a_ms), 1);
      if (i == 6) begin
        chk("hold_last_s", int'(a_ms), 3);
        chk("hold_last_flag", int'(a_last), 1);
        chk("hold_last_in_ready", int'(a_rdy), 0);
      end
      @(posedge clk); #1;
    end
    a_hld = 1'b0;
    @(negedge clk);
    chk("hold_done_at_7", int'(a_done), 1);
    chk("hold_idle_sv", int'(a_sv), 0);
    @(posedge clk); #1;

    // Asynchronous reset mid-word at s=2 (word 0110)
    exp_beat(0, 0, 0, 0); exp_beat(0, 1, 1, 0);
    send(0, 8'h06, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mux_i", int'(a_mi), 0);
    chk("arst_mux_s", int'(a_ms), 0);
    chk("arst_sel_valid", int'(a_sv), 0);
    chk("arst_last", int'(a_last), 0);
    chk("arst_done", int'(a_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Next word after reset starts at s=0: 1001 -> y 1,0,0,1
    exp_beat(0, 0, 1, 0); exp_beat(0, 1, 0, 0); exp_beat(0, 2, 0, 0); exp_beat(0, 3, 1, 1);
    send(0, 8'h09, 1'b0);
    idle_chk(0, 5);

    // WIDTH=8: A5 -> s 0..7 / y 1,0,1,0,0,1,0,1
    exp_beat(2, 0, 1, 0); exp_beat(2, 1, 0, 0); exp_beat(2, 2, 1, 0); exp_beat(2, 3, 0, 0);
    exp_beat(2, 4, 0, 0); exp_beat(2, 5, 1, 0); exp_beat(2, 6, 0, 0); exp_beat(2, 7, 1, 1);
    send(2, 8'hA5, 1'b0);
    idle_chk(2, 9);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_remaining", q0.size(), 0);
    chk("q1_remaining", q1.size(), 0);
    chk("q2_remaining", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
